// File: rtl/lcd_timing_if.sv
// Pixel-side bundle between the LCD timing driver, the pixel renderer and the panel.
// The master is the timing driver: it issues coordinates and drives the panel pins.
interface lcd_timing_if;
  logic [15:0] pixel_data;
  logic [9:0]  pixel_xpos;
  logic [9:0]  pixel_ypos;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [15:0] lcd_rgb;
  logic        frame_start;

  modport master (
    input  pixel_data,
    output pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
  );

  modport slave (
    output pixel_data,
    input  pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
  );
endinterface

// File: rtl/lcd_timing_driver.sv
// Free-running raster timing generator: requests pixel coordinates one clock ahead
// so the renderer's registered colour lands on the matching lcd_de cycle.
module lcd_timing_driver #(
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BACK   = 64,
  parameter int unsigned H_DISP   = 800,
  parameter int unsigned H_FRONT  = 56,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BACK   = 23,
  parameter int unsigned V_DISP   = 600,
  parameter int unsigned V_FRONT  = 37,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic         lcd_clk,
  input  logic         sys_rst_n,
  lcd_timing_if.master bus
);

  localparam logic [10:0] H_MAX    = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [10:0] V_MAX    = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [10:0] HA       = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HE       = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] VA       = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VE       = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] HS_END   = 11'(H_SYNC);
  localparam logic [10:0] VS_END   = 11'(V_SYNC);
  localparam logic        SYNC_IDLE = ~SYNC_POL;

  // Stage 0: raster counters
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        req0, hs0, vs0, first0;

  // Stage 1: coordinate request plus delayed timing flags
  logic [9:0]  xpos_q, xpos_d;
  logic [9:0]  ypos_q, ypos_d;
  logic        req1_q, hs1_q, vs1_q, first1_q;

  // Stage 2: panel-facing timing
  logic        de_q, hs_q, hs_d, vs_q, vs_d, fs_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_MAX) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_MAX) ? 11'd0 : v_cnt_q + 11'd1;
    end

    req0   = (h_cnt_q >= HA) && (h_cnt_q < HE) && (v_cnt_q >= VA) && (v_cnt_q < VE);
    hs0    = (h_cnt_q < HS_END);
    vs0    = (v_cnt_q < VS_END);
    first0 = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);

    xpos_d = req0 ? 10'(h_cnt_q - HA) : 10'd0;
    ypos_d = req0 ? 10'(v_cnt_q - VA) : 10'd0;

    // XNOR with the polarity: active-high passes through, active-low inverts
    hs_d = hs1_q ~^ SYNC_POL;
    vs_d = vs1_q ~^ SYNC_POL;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge lcd_clk) begin
    if (!sys_rst_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      xpos_q   <= '0;
      ypos_q   <= '0;
      req1_q   <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      first1_q <= 1'b0;
      de_q     <= 1'b0;
      hs_q     <= SYNC_IDLE;
      vs_q     <= SYNC_IDLE;
      fs_q     <= 1'b0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      req1_q   <= req0;
      hs1_q    <= hs0;
      vs1_q    <= vs0;
      first1_q <= first0;
      de_q     <= req1_q;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= first1_q;
    end
  end

  assign bus.pixel_xpos  = xpos_q;
  assign bus.pixel_ypos  = ypos_q;
  assign bus.lcd_de      = de_q;
  assign bus.lcd_hs      = hs_q;
  assign bus.lcd_vs      = vs_q;
  assign bus.frame_start = fs_q;
  // Renderer output is already registered; only blanking is applied here
  assign bus.lcd_rgb     = de_q ? bus.pixel_data : 16'h0000;

endmodule

// File: doc/lcd_timing_driver.md
# lcd_timing_driver

Display-side timing generator for the waveform VGA/LCD path, running on `lcd_clk`. It scans a fixed raster and issues `pixel_xpos`/`pixel_ypos` requests to the pixel renderer. It takes back the renderer's registered `pixel_data` (RGB565) and drives the panel/VGA DAC with sync, data-enable and colour. Request and return are skewed so the colour lines up with `lcd_de`, absorbing the renderer's one-cycle register stage.

## Interface
Parameters (defaults: 800x600 @ 72 Hz, 50 MHz `lcd_clk`):
- `H_SYNC`, 120, horizontal sync width in clocks
- `H_BACK`, 64, horizontal back porch
- `H_DISP`, 800, active pixels per line
- `H_FRONT`, 56, horizontal front porch
- `V_SYNC`, 6, vertical sync width in lines
- `V_BACK`, 23, vertical back porch
- `V_DISP`, 600, active lines per frame
- `V_FRONT`, 37, vertical front porch
- `SYNC_POL`, 1, sync active level (1 = active-high)

Ports:
- `lcd_clk`  in  1  pixel clock; the only clock
- `sys_rst_n`  in  1  reset; synchronous, active-low
- `pixel_data`  in  16  RGB565 from renderer; valid one clock after the matching coordinate
- `pixel_xpos`  out  10  requested column, 0..H_DISP-1
- `pixel_ypos`  out  10  requested row, 0..V_DISP-1
- `lcd_hs`  out  1  horizontal sync
- `lcd_vs`  out  1  vertical sync
- `lcd_de`  out  1  active-video data enable
- `lcd_rgb`  out  16  RGB565 to panel; zero outside active video
- `frame_start`  out  1  one-clock pulse at the first clock of each frame's vertical sync

## Operation
- Derived constants: H_TOTAL = sum of the H terms (1040); V_TOTAL = sum of the V terms (666); HA = H_SYNC+H_BACK (184); VA = V_SYNC+V_BACK (29).
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments only on the clock where `h_cnt` wraps. `v_cnt` wraps to 0 after V_TOTAL-1. Both counters are 11 bits wide.
- Stage 0 (counter state), per clock:
  - req = (HA ≤ h_cnt < HA+H_DISP) and (VA ≤ v_cnt < VA+V_DISP)
  - hs0 = h_cnt < H_SYNC
  - vs0 = v_cnt < V_SYNC
- Stage 1 (registered):
  - `pixel_xpos` = req ? h_cnt-HA : 0
  - `pixel_ypos` = req ? v_cnt-VA : 0
  - req, hs0 and vs0 are each delayed by one register
- Stage 2 (registered):
  - `lcd_de` = req delayed two clocks
  - `lcd_hs` = hs0 delayed two clocks, XNOR-mapped through SYNC_POL
  - `lcd_vs` = vs0 delayed two clocks, XNOR-mapped through SYNC_POL
- `lcd_rgb` = `lcd_de` ? `pixel_data` : 16'h0000, combinational gating of the renderer's registered output.
- `frame_start` is registered. It is high for exactly the one clock where `lcd_vs` first goes active, i.e. stage-2 alignment of h_cnt=0, v_cnt=0.
- Coordinates are truncated to 10 bits. Parameters must keep H_DISP and V_DISP ≤ 1024 and H_TOTAL and V_TOTAL ≤ 2047.

## Timing
- Reset (`sys_rst_n` = 0 at a `lcd_clk` edge):
  - `h_cnt` = `v_cnt` = 0
  - all pipeline registers clear
  - `pixel_xpos` = `pixel_ypos` = 0; `lcd_de` = 0; `frame_start` = 0
  - `lcd_hs`/`lcd_vs` go to the inactive level (0 for SYNC_POL=1)
- Reset mid-frame takes effect at the next edge, with no partial-line completion.
- First clock after release: counters are at (0,0). Stage-2 outputs show the frame start two clocks later.
- Latency: counter → coordinates is 1 clock; counter → `lcd_hs`/`lcd_vs`/`lcd_de` is 2 clocks. `pixel_data` arriving 1 clock after its coordinate lands on the `lcd_de` cycle of that coordinate.
- Line wrap: on the clock `h_cnt` goes H_TOTAL-1 → 0, `v_cnt` advances in the same edge.
- Frame wrap: (H_TOTAL-1, V_TOTAL-1) → (0,0) in one edge.
- Active window per line: exactly H_DISP consecutive `lcd_de` clocks. Active window per frame: V_DISP lines.
- No stalls and no handshake back-pressure; the raster is free-running.

## Test plan
- Reset: hold `sys_rst_n`=0 for 5 clocks, release → `lcd_de`=0, `lcd_hs`=`lcd_vs`=0, coordinates 0. `frame_start` pulses at clock 2 after release; `lcd_hs` rises on the same clock and stays high for 120 clocks.
- First pixel: count from release → `pixel_xpos`=0, `pixel_ypos`=0 at clock 29·1040+184+1. `lcd_de` rises one clock later. `pixel_xpos` reaches 799 after 799 further clocks.
- Alignment: drive `pixel_data` as a register of {pixel_ypos[5:0], pixel_xpos[9:0]} → every `lcd_de` cycle shows `lcd_rgb` equal to the expected coordinate; `lcd_rgb`=0 whenever `lcd_de`=0.
- Line/frame wrap: run 2 frames → `frame_start` period is exactly 692640 clocks; 600 lines of 800 `lcd_de` clocks per frame; `lcd_vs` is high for 6·1040 clocks.
- Polarity: SYNC_POL=0 → `lcd_hs`/`lcd_vs` are inverted versions of the SYNC_POL=1 run; they idle high in reset.
- Reset mid-line: assert reset at `pixel_xpos`=400 on line 300 → next edge clears all outputs; the restart timing is identical to the first scenario.
